// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding a UART transmitter through a launch/handshake
//               FSM, with sticky overflow and transmitter-timeout flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int BUSY_TMO = 15
) (
    input  logic        sys_clk,
    input  logic        sys_rst_l,
    input  logic        wr_enH,
    input  logic [7:0]  wr_dataH,
    output logic        fullH,
    output logic        emptyH,
    output logic [AW:0] countH,
    output logic        overflowH,
    output logic        timeout_errH,
    input  logic        clr_errH,
    output logic        xmitH,
    output logic [7:0]  xmit_dataH,
    input  logic        xmit_doneH,
    output logic        tx_busyH
);

    localparam int TW = $clog2(BUSY_TMO + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [TW-1:0]   tmo_inc;
    logic            ovf_q, ovf_d;
    logic            terr_q, terr_d;
    logic [7:0]      xdata_q, xdata_d;
    logic [7:0]      mem_q [DEPTH];

    logic            pop;
    logic            push_ok;
    logic            ovf_set;
    logic            tmo_set;

    assign fullH        = (count_q == (AW+1)'(DEPTH));
    assign emptyH       = (count_q == '0);
    assign countH       = count_q;
    assign overflowH    = ovf_q;
    assign timeout_errH = terr_q;
    assign xmitH        = (state_q == LAUNCH);
    assign xmit_dataH   = xdata_q;
    assign tx_busyH     = (state_q != IDLE);
    assign tmo_inc      = tmo_q + 1'b1;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        xdata_d = xdata_q;
        pop     = 1'b0;
        tmo_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!emptyH && xmit_doneH) begin
                    state_d = LAUNCH;
                    xdata_d = mem_q[rd_ptr_q];
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
                tmo_d   = '0;
            end
            WAIT_BUSY: begin
                if (!xmit_doneH) begin
                    state_d = WAIT_DONE;
                end else begin
                    tmo_d = tmo_inc;
                    // No pop on timeout: the head byte is relaunched from IDLE.
                    if (tmo_inc == TW'(BUSY_TMO)) begin
                        tmo_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (xmit_doneH) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push_ok = wr_enH && (!fullH || pop);
    assign ovf_set = wr_enH && fullH && !pop;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d  = ovf_set | (ovf_q & ~clr_errH);
        terr_d = tmo_set | (terr_q & ~clr_errH);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tmo_q    <= '0;
            ovf_q    <= 1'b0;
            terr_q   <= 1'b0;
            xdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tmo_q    <= tmo_d;
            ovf_q    <= ovf_d;
            terr_q   <= terr_d;
            xdata_q  <= xdata_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_dataH;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo against a queue-based
//               transaction model and a randomized transmitter responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int BUSY_TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clr_err;
    logic        done;
    logic        full, empty, ovf, terr, xmit, busy;
    logic [AW:0] count;
    logic [7:0]  xdata;

    int checks = 0;
    int errors = 0;

    // Transaction model: FIFO contents, expected flags, transmitter phase
    // (0 idle, 1 launched and awaiting busy, 2 transmitter busy).
    logic [7:0] m_q[$];
    logic       m_launch, m_ovf, m_tmo;
    logic [7:0] m_data;
    int         m_phase, m_tcnt;
    bit         tx_auto;
    int         tx_wait, tx_low;
    logic [7:0] log_q[$];
    logic [7:0] pushed[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .BUSY_TMO(BUSY_TMO)) dut (
        .sys_clk     (clk),
        .sys_rst_l   (rst_n),
        .wr_enH      (wr_en),
        .wr_dataH    (wr_data),
        .fullH       (full),
        .emptyH      (empty),
        .countH      (count),
        .overflowH   (ovf),
        .timeout_errH(terr),
        .clr_errH    (clr_err),
        .xmitH       (xmit),
        .xmit_dataH  (xdata),
        .xmit_doneH  (done),
        .tx_busyH    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_launch = 1'b0;
        m_ovf    = 1'b0;
        m_tmo    = 1'b0;
        m_data   = 8'h00;
        m_phase  = 0;
        m_tcnt   = 0;
        tx_wait  = 0;
        tx_low   = 0;
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("timeout_err", 32'(terr), 32'(m_tmo));
        chk("xmit", 32'(xmit), 32'(m_launch));
        chk("tx_busy", 32'(busy), 32'((m_phase != 0) || m_launch));
        chk("xmit_data", 32'(xdata), 32'(m_data));
        if (xmit === 1'b1) log_q.push_back(xdata);
    endtask

    // Advance one clock: update the model with this cycle's inputs, then check.
    task automatic cyc();
        logic pop, nl, full_now, acc, oset, tset;
        pop = 1'b0; nl = 1'b0; tset = 1'b0;
        if (tx_auto) begin
            if (m_launch) begin
                tx_wait = int'($urandom_range(0, 3));
                tx_low  = int'($urandom_range(1, 6));
                done    = 1'b1;
            end else if (tx_wait > 0) begin
                tx_wait--;
                done = 1'b1;
            end else if (tx_low > 0) begin
                tx_low--;
                done = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        if (m_launch) begin
            m_phase = 1;
            m_tcnt  = 0;
        end else if (m_phase == 1) begin
            if (!done) m_phase = 2;
            else begin
                m_tcnt++;
                if (m_tcnt == BUSY_TMO) begin
                    tset    = 1'b1;
                    m_phase = 0;
                end
            end
        end else if (m_phase == 2) begin
            if (done) begin
                pop     = 1'b1;
                m_phase = 0;
            end
        end else if (m_q.size() > 0 && done) begin
            nl     = 1'b1;
            m_data = m_q[0];
        end
        full_now = (m_q.size() == DEPTH);
        acc      = wr_en && (!full_now || pop);
        oset     = wr_en && full_now && !pop;
        m_ovf    = oset ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
        m_tmo    = tset ? 1'b1 : (clr_err ? 1'b0 : m_tmo);
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(wr_data);
        m_launch = nl;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && !(m_q.size() == 0 && m_phase == 0 && !m_launch); i++) cyc();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
        done = 1'b1; tx_auto = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();

        // Single byte with a slow transmitter
        wr_en = 1'b1; wr_data = 8'hA5; cyc();
        wr_en = 1'b0;
        chk("t1_empty_n1", 32'(empty), 32'd0);
        chk("t1_xmit_n1", 32'(xmit), 32'd0);
        cyc();
        chk("t1_xmit_n2", 32'(xmit), 32'd1);
        chk("t1_data_n2", 32'(xdata), 32'hA5);
        cyc();
        chk("t1_xmit_n3", 32'(xmit), 32'd0);
        cyc();
        done = 1'b0;
        repeat (38) cyc();
        done = 1'b1;
        cyc();
        chk("t1_empty_end", 32'(empty), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Fill and overflow; the last push collides with clr_err and must win
        done = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); clr_err = (i == 9);
            cyc();
        end
        wr_en = 1'b0; clr_err = 1'b0;
        chk("t2_count", 32'(count), 32'd8);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_ovf_set", 32'(ovf), 32'd1);
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        chk("t2_ovf_clr", 32'(ovf), 32'd0);

        // Full FIFO: push during the WAIT_DONE pop cycle
        log_q.delete();
        done = 1'b1;
        for (int i = 0; i < 5 && xmit !== 1'b1; i++) cyc();
        chk("t3_launch", 32'(xmit), 32'd1);
        chk("t3_data", 32'(xdata), 32'h01);
        done = 1'b0; cyc(); cyc();
        done = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; cyc();
        wr_en = 1'b0;
        chk("t3_count", 32'(count), 32'd8);
        chk("t3_ovf", 32'(ovf), 32'd0);
        tx_auto = 1'b1;
        drain();
        chk("t3_len", 32'(log_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < log_q.size(); i++)
            chk($sformatf("t3_order%0d", i), 32'(log_q[i]), (i < 8) ? 32'(i + 1) : 32'hEE);

        // Stream across pointer wrap with the randomized transmitter
        log_q.delete(); pushed.delete();
        for (int i = 0; i < 20; i++) begin
            for (int w = 0; w < 200 && m_q.size() >= DEPTH; w++) cyc();
            wr_en = 1'b1; wr_data = 8'(8'h10 + i); cyc();
            wr_en = 1'b0;
            pushed.push_back(8'(8'h10 + i));
            repeat ($urandom_range(0, 2)) cyc();
        end
        drain();
        chk("t4_len", 32'(log_q.size()), 32'd20);
        for (int i = 0; i < 20 && i < log_q.size(); i++)
            chk($sformatf("t4_order%0d", i), 32'(log_q[i]), 32'(pushed[i]));

        // Transmitter never goes busy: timeout, retry of the same byte
        tx_auto = 1'b0; done = 1'b1;
        wr_en = 1'b1; wr_data = 8'h5A; cyc();
        wr_data = 8'h6B; cyc();
        wr_en = 1'b0;
        chk("t5_launch", 32'(xmit), 32'd1);
        chk("t5_data", 32'(xdata), 32'h5A);
        repeat (BUSY_TMO) cyc();
        chk("t5_busy_last", 32'(busy), 32'd1);
        chk("t5_tmo_pre", 32'(terr), 32'd0);
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        chk("t5_tmo_set", 32'(terr), 32'd1);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_count", 32'(count), 32'd2);
        cyc();
        chk("t5_relaunch", 32'(xmit), 32'd1);
        chk("t5_redata", 32'(xdata), 32'h5A);
        clr_err = 1'b1; done = 1'b0; cyc(); clr_err = 1'b0;
        chk("t5_tmo_clr", 32'(terr), 32'd0);
        cyc();
        tx_auto = 1'b1;
        drain();

        // Reset during WAIT_DONE with 5 entries queued
        tx_auto = 1'b0; done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i); cyc();
        end
        wr_en = 1'b0; done = 1'b1;
        for (int i = 0; i < 5 && xmit !== 1'b1; i++) cyc();
        chk("t6_launch", 32'(xmit), 32'd1);
        chk("t6_data", 32'(xdata), 32'h30);
        done = 1'b0; cyc(); cyc();
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_count", 32'(count), 32'd5);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all();
        log_q.delete();
        repeat (6) cyc();
        chk("t6_no_launch", 32'(log_q.size()), 32'd0);
        wr_en = 1'b1; wr_data = 8'h77; cyc();
        wr_en = 1'b0; cyc();
        chk("t6_new_launch", 32'(xmit), 32'd1);
        chk("t6_new_data", 32'(xdata), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
